// File: rtl/irq_controller.sv
// irq_controller: edge-latched, maskable, fixed-priority interrupt front-end (option macro IRQ_SYNC_EN adds 2-flop input synchronisers)
module irq_controller #(
    parameter int N = 8,
    parameter int VECW = 3,
    parameter logic [N-1:0] MASK_RST = 8'hFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    interrupts,
    input  logic            mask_we,
    input  logic [N-1:0]    mask_wd,
    input  logic            irqack,
    output logic            irq,
    output logic [VECW-1:0] irqvec,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    mask
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;
    state_t state, state_n;
    logic [N-1:0] s_cur, s_prev, req, clr;
    logic [VECW-1:0] win;
    logic ack_ok;
`ifdef IRQ_SYNC_EN
    logic [N-1:0] s_meta, s_sync;
    // two-flop synchroniser for asynchronous pads
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s_meta <= '0;
            s_sync <= '0;
        end else begin
            s_meta <= interrupts;
            s_sync <= s_meta;
        end
    assign s_cur = s_sync;
`else
    assign s_cur = interrupts;
`endif
    assign req    = pending & mask;
    assign ack_ok = (state == ASSERT) && irqack;
    assign clr    = ack_ok ? (N'(1) << irqvec) : '0;
    // lowest-index enabled pending source wins
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) win = VECW'(i);
    end
    // next-state: request is frozen in ASSERT, one idle HOLDOFF cycle after ack
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |req ? ASSERT : IDLE;
            ASSERT:  state_n = irqack ? HOLDOFF : ASSERT;
            HOLDOFF: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // edge history, pending (set beats clear), mask, FSM and registered request
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s_prev  <= '0;
            pending <= '0;
            mask    <= MASK_RST;
            state   <= IDLE;
            irq     <= 1'b0;
            irqvec  <= '0;
        end else begin
            s_prev  <= s_cur;
            pending <= (pending & ~clr) | (s_cur & ~s_prev);
            mask    <= mask_we ? mask_wd : mask;
            state   <= state_n;
            irq     <= state_n == ASSERT;
            irqvec  <= (state == IDLE && |req) ? win : irqvec;
        end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: randomized and directed checks of irq_controller against a behavioural model
module tb_irq_controller;
`ifdef IRQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    logic clk = 0, reset = 0, mask_we = 0, irqack = 0;
    logic [7:0] interrupts = 0, mask_wd = 0, pending, mask;
    logic irq;
    logic [2:0] irqvec;
    int checks = 0, failures = 0;

    // reference model: event history, pending set, mask, request state
    logic [7:0] q[$];
    logic [7:0] m_prev, m_pend, m_mask;
    bit m_busy, m_gap;
    int m_vec;

    irq_controller dut (
        .clk(clk), .reset(reset), .interrupts(interrupts), .mask_we(mask_we),
        .mask_wd(mask_wd), .irqack(irqack), .irq(irq), .irqvec(irqvec),
        .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prev = 0; m_pend = 0; m_mask = 8'hFF; m_busy = 0; m_gap = 0; m_vec = 0;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] cur, ev, nxt;
        q.push_back(interrupts);
        if (q.size() > 4) void'(q.pop_front());
        cur = (q.size() > L) ? q[q.size() - 1 - L] : 8'h00;
        ev = cur & ~m_prev;
        m_prev = cur;
        nxt = m_pend;
        if (m_busy && irqack) nxt[m_vec] = 1'b0;
        nxt |= ev;
        if (m_busy) begin
            if (irqack) begin m_busy = 0; m_gap = 1; end
        end else if (m_gap) m_gap = 0;
        else if ((m_pend & m_mask) != 0) begin m_vec = lowest(m_pend & m_mask); m_busy = 1; end
        m_pend = nxt;
        if (mask_we) m_mask = mask_wd;
    endtask

    task automatic cyc(input logic [7:0] in, input bit ack = 0, input bit we = 0, input logic [7:0] wd = 0);
        interrupts = in; irqack = ack; mask_we = we; mask_wd = wd;
        @(posedge clk);
        model_step();
        #1;
        check("irq", {7'd0, irq}, {7'd0, m_busy});
        check("pending", pending, m_pend);
        check("mask", mask, m_mask);
        if (m_busy) check("irqvec", {5'd0, irqvec}, 8'(m_vec));
    endtask

    task automatic drain();
        int n = 0;
        while ((m_busy || m_gap || m_pend != 0 || m_mask != 8'hFF) && n < 60) begin
            cyc(0, m_busy, m_mask != 8'hFF, 8'hFF);
            n++;
        end
        cyc(0);
        check("drain_timeout", 8'(n < 60), 8'd1);
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!m_busy && n < 10) begin cyc(0); n++; end
        check(tag, {7'd0, irq}, 8'd1);
    endtask

    initial begin
        logic [7:0] sp, sm;
        logic si;
        logic [2:0] sv;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", {7'd0, irq}, 8'd0);
        check("rst_pend", pending, 8'h00);
        check("rst_mask", mask, 8'hFF);
        check("rst_vec", {5'd0, irqvec}, 8'd0);
        reset = 1;
        cyc(0);

        // single pulse on bit 1: pending after L edges, irq one edge later, held
        cyc(8'h02);
        repeat (L) cyc(0);
        check("lat_pend", pending, 8'h02);
        check("lat_noirq", {7'd0, irq}, 8'd0);
        cyc(0);
        check("lat_irq", {7'd0, irq}, 8'd1);
        check("lat_vec", {5'd0, irqvec}, 8'd1);
        repeat (4) cyc(0);
        check("hold_irq", {7'd0, irq}, 8'd1);
        cyc(0, 1);
        check("ack_drop", {7'd0, irq}, 8'd0);
        drain();

        // simultaneous bits 0 and 1: vec 0, two low cycles, then vec 1
        cyc(8'h03);
        wait_irq("both_irq");
        check("both_vec0", {5'd0, irqvec}, 8'd0);
        cyc(0, 1);
        check("both_hold", {7'd0, irq}, 8'd0);
        cyc(0);
        check("both_idle", {7'd0, irq}, 8'd0);
        cyc(0);
        check("both_irq1", {7'd0, irq}, 8'd1);
        check("both_vec1", {5'd0, irqvec}, 8'd1);
        drain();

        // masked source latches but does not request until unmasked
        cyc(0, 0, 1, 8'hFE);
        cyc(8'h01);
        repeat (L + 3) cyc(0);
        check("msk_pend", pending, 8'h01);
        check("msk_noirq", {7'd0, irq}, 8'd0);
        cyc(0, 0, 1, 8'hFF);
        check("msk_wr_noirq", {7'd0, irq}, 8'd0);
        cyc(0);
        check("msk_irq", {7'd0, irq}, 8'd1);
        check("msk_vec", {5'd0, irqvec}, 8'd0);
        drain();

        // new edge on bit 1 in the same cycle as its ack: set wins
        cyc(8'h02);
        wait_irq("sw_irq");
        cyc(8'h02, L == 0);
        repeat (L > 0 ? L - 1 : 0) cyc(0);
        if (L > 0) cyc(0, 1);
        check("sw_pend", pending, 8'h02);
        check("sw_hold", {7'd0, irq}, 8'd0);
        cyc(0);
        cyc(0);
        check("sw_irq2", {7'd0, irq}, 8'd1);
        check("sw_vec", {5'd0, irqvec}, 8'd1);
        drain();

        // ack while idle with nothing pending changes nothing
        sp = pending; sm = mask; si = irq; sv = irqvec;
        cyc(0, 1);
        check("idle_ack_irq", {7'd0, irq}, {7'd0, si});
        check("idle_ack_pend", pending, sp);
        check("idle_ack_mask", mask, sm);
        check("idle_ack_vec", {5'd0, irqvec}, {5'd0, sv});

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] in;
            in = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : interrupts;
            cyc(in, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, 8'($urandom) | 8'h10);
        end
        drain();

        // asynchronous reset in the middle of a request
        cyc(0, 0, 1, 8'h0F);
        cyc(8'h08);
        wait_irq("mid_irq");
        #2 reset = 0;
        #1;
        check("mid_rst_irq", {7'd0, irq}, 8'd0);
        check("mid_rst_pend", pending, 8'h00);
        check("mid_rst_vec", {5'd0, irqvec}, 8'd0);
        check("mid_rst_mask", mask, 8'hFF);
        model_reset();
        interrupts = 0;
        #1 reset = 1;
        repeat (3) cyc(0);
        cyc(8'h40);
        wait_irq("post_rst_irq");
        check("post_rst_vec", {5'd0, irqvec}, 8'd6);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
